// File: rtl/key_evt_deb.sv
// Multi-key debouncer with press/release/long-press events, 2-flop input sync per key.
// Optional auto-repeat in the LONG state is compiled in when KEY_REPEAT_EN is defined.
module key_evt_deb #(
  parameter int unsigned       KEY_WIDTH  = 1,
  parameter bit                ACTIVE_LOW = 1'b1,
  parameter int unsigned       DEB_W      = 20,
  parameter logic [DEB_W-1:0]  DEB_MAX    = 20'h7_ffff,
  parameter int unsigned       HOLD_W     = 24,
  parameter logic [HOLD_W-1:0] LONG_MAX   = 24'd2_000_000,
  parameter logic [HOLD_W-1:0] REPEAT_MAX = 24'd250_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] key_deb,
  output logic [KEY_WIDTH-1:0] press_pls,
  output logic [KEY_WIDTH-1:0] release_pls,
  output logic [KEY_WIDTH-1:0] long_pls,
  output logic [KEY_WIDTH-1:0] rpt_pls
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_e;

  localparam logic IDLE_LVL  = ACTIVE_LOW;
  localparam logic PRESS_LVL = ~ACTIVE_LOW;

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              deb_q, deb_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              rpt_q, rpt_d;
    logic              pressed;

    // Debounce: any cycle where s2 matches the accepted level restarts the count.
    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      s1_d      = key_in[i];
      s2_d      = s1_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (s2_q != deb_q) begin
        if (deb_cnt_q == DEB_MAX) begin
          deb_d = s2_q;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    end

    assign pressed = (deb_q == PRESS_LVL);

    // Event FSM works from the registered debounced level, so every pulse trails key_deb by one cycle.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      rpt_d      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            press_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            release_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end else if (hold_cnt_q == LONG_MAX - HOLD_W'(1)) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (!pressed) begin
            release_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
`ifdef KEY_REPEAT_EN
            if (hold_cnt_q == REPEAT_MAX - HOLD_W'(1)) begin
              rpt_d      = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
`else
            hold_cnt_d = '0;
`endif
          end
        end
        default: begin
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) begin
        s1_q       <= IDLE_LVL;
        s2_q       <= IDLE_LVL;
        deb_q      <= IDLE_LVL;
        deb_cnt_q  <= '0;
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        s1_q       <= s1_d;
        s2_q       <= s2_d;
        deb_q      <= deb_d;
        deb_cnt_q  <= deb_cnt_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
        rpt_q      <= rpt_d;
      end
    end

    assign key_deb[i]     = deb_q;
    assign press_pls[i]   = press_q;
    assign release_pls[i] = release_q;
    assign long_pls[i]    = long_q;
    assign rpt_pls[i]     = rpt_q;
  end

endmodule
